decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//   RV32I instruction decode stage: 32x32 register file (optional
//   same-cycle writeback bypass), immediate generation, ALU-op/control
//   decode, load-use hazard detection and the ID/EX pipeline register.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   pc_i, instr_i     IF/ID contents (instr_i == 0 is a bubble)
//   flush_i           redirect: kill the instruction currently in ID
//   wb_we_i/rd_i/data_i  register-file write port
//   hazard_o          combinational load-use stall request to fetch
//   valid_ex .. ctrl_ex  ID/EX register outputs
//   illegal_o         one-cycle pulse for an accepted unsupported opcode
//
// Stall handshake: while hazard_o=1 the upstream holds pc_i/instr_i stable
// and this stage loads a bubble into ID/EX. Because the bubble clears
// valid_ex, hazard_o drops on the next cycle and the held instruction
// issues, so each load-use pair costs exactly one stall cycle.
// ---------------------------------------------------------------------------
module decode_stage #(
   parameter bit WB_BYPASS = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_i,
   input  logic [31:0] instr_i,
   input  logic        flush_i,
   input  logic        wb_we_i,
   input  logic [4:0]  wb_rd_i,
   input  logic [31:0] wb_data_i,
   output logic        hazard_o,
   output logic        valid_ex,
   output logic [31:0] pc_ex,
   output logic [31:0] rs1_data_ex,
   output logic [31:0] rs2_data_ex,
   output logic [31:0] imm_ex,
   output logic [4:0]  rd_ex,
   output logic [4:0]  rs1_ex,
   output logic [4:0]  rs2_ex,
   output logic [3:0]  alu_op_ex,
   output logic [2:0]  funct3_ex,
   output logic [6:0]  ctrl_ex,
   output logic        illegal_o
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2,
                          ALU_SLT = 4'd3, ALU_SLTU = 4'd4, ALU_XOR = 4'd5,
                          ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8,
                          ALU_AND = 4'd9, ALU_PASSB = 4'd10;

   // instr[30] selects SUB only for register-register ops; for shifts it
   // selects arithmetic right shift in both OP and OP-IMM.
   function automatic logic [3:0] alu_from_f3(input logic [2:0] f3,
                                              input logic b30,
                                              input logic is_op);
      logic [3:0] a;
      case (f3)
         3'd0:    a = (is_op && b30) ? ALU_SUB : ALU_ADD;
         3'd1:    a = ALU_SLL;
         3'd2:    a = ALU_SLT;
         3'd3:    a = ALU_SLTU;
         3'd4:    a = ALU_XOR;
         3'd5:    a = b30 ? ALU_SRA : ALU_SRL;
         3'd6:    a = ALU_OR;
         default: a = ALU_AND;
      endcase
      return a;
   endfunction

   logic [31:0] rf [32];

   logic [6:0]  opcode;
   logic [4:0]  rd_f, rs1_f, rs2_f;
   logic [2:0]  f3;
   logic        legal, writes_rd, rs1_used, rs2_used;
   logic        is_load, is_store, is_branch, is_jal, is_jalr, alu_src_imm;
   logic [3:0]  alu_op;
   logic [31:0] imm;
   logic        reg_we;
   logic [4:0]  rd_dec, rs1_idx, rs2_idx;
   logic [31:0] rs1_val, rs2_val;
   logic        accept, illegal_next;

   assign opcode = instr_i[6:0];
   assign rd_f   = instr_i[11:7];
   assign f3     = instr_i[14:12];
   assign rs1_f  = instr_i[19:15];
   assign rs2_f  = instr_i[24:20];

   always_comb begin
      legal       = 1'b0;
      writes_rd   = 1'b0;
      rs1_used    = 1'b0;
      rs2_used    = 1'b0;
      is_load     = 1'b0;
      is_store    = 1'b0;
      is_branch   = 1'b0;
      is_jal      = 1'b0;
      is_jalr     = 1'b0;
      alu_src_imm = 1'b0;
      alu_op      = ALU_ADD;
      imm         = 32'h0;
      case (opcode)
         OPC_LUI: begin
            legal = 1'b1; writes_rd = 1'b1; alu_src_imm = 1'b1;
            alu_op = ALU_PASSB;
            imm = {instr_i[31:12], 12'h0};
         end
         OPC_AUIPC: begin
            legal = 1'b1; writes_rd = 1'b1; alu_src_imm = 1'b1;
            imm = {instr_i[31:12], 12'h0};
         end
         OPC_JAL: begin
            legal = 1'b1; writes_rd = 1'b1; alu_src_imm = 1'b1; is_jal = 1'b1;
            imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                   instr_i[20], instr_i[30:21], 1'b0};
         end
         OPC_JALR: begin
            legal = 1'b1; writes_rd = 1'b1; alu_src_imm = 1'b1; is_jalr = 1'b1;
            rs1_used = 1'b1;
            imm = {{20{instr_i[31]}}, instr_i[31:20]};
         end
         OPC_BRANCH: begin
            legal = 1'b1; is_branch = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
            alu_op = ALU_SUB;
            imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                   instr_i[30:25], instr_i[11:8], 1'b0};
         end
         OPC_LOAD: begin
            legal = 1'b1; writes_rd = 1'b1; alu_src_imm = 1'b1; is_load = 1'b1;
            rs1_used = 1'b1;
            imm = {{20{instr_i[31]}}, instr_i[31:20]};
         end
         OPC_STORE: begin
            legal = 1'b1; alu_src_imm = 1'b1; is_store = 1'b1;
            rs1_used = 1'b1; rs2_used = 1'b1;
            imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         end
         OPC_OPIMM: begin
            legal = 1'b1; writes_rd = 1'b1; alu_src_imm = 1'b1; rs1_used = 1'b1;
            alu_op = alu_from_f3(f3, instr_i[30], 1'b0);
            imm = {{20{instr_i[31]}}, instr_i[31:20]};
         end
         OPC_OP: begin
            legal = 1'b1; writes_rd = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
            alu_op = alu_from_f3(f3, instr_i[30], 1'b1);
         end
         default: ;
      endcase
   end

   // Fields the format does not carry are reported as index 0.
   assign reg_we  = writes_rd && (rd_f != 5'd0);
   assign rd_dec  = writes_rd ? rd_f  : 5'd0;
   assign rs1_idx = rs1_used  ? rs1_f : 5'd0;
   assign rs2_idx = rs2_used  ? rs2_f : 5'd0;

   assign rs1_val = (rs1_idx == 5'd0) ? 32'h0 :
                    (WB_BYPASS && wb_we_i && (wb_rd_i == rs1_idx)) ? wb_data_i :
                    rf[rs1_idx];
   assign rs2_val = (rs2_idx == 5'd0) ? 32'h0 :
                    (WB_BYPASS && wb_we_i && (wb_rd_i == rs2_idx)) ? wb_data_i :
                    rf[rs2_idx];

   // ctrl_ex[4] is is_load of the instruction sitting in EX.
   assign hazard_o = !reset && !flush_i && valid_ex && ctrl_ex[4] &&
                     (rd_ex != 5'd0) &&
                     ((rs1_used && (rs1_f == rd_ex)) ||
                      (rs2_used && (rs2_f == rd_ex)));

   assign accept       = (instr_i != 32'h0) && legal && !flush_i && !hazard_o;
   assign illegal_next = (instr_i != 32'h0) && !legal && !flush_i;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
      end else if (wb_we_i && (wb_rd_i != 5'd0)) begin
         rf[wb_rd_i] <= wb_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_ex    <= 1'b0;
         illegal_o   <= 1'b0;
         pc_ex       <= 32'h0;
         rs1_data_ex <= 32'h0;
         rs2_data_ex <= 32'h0;
         imm_ex      <= 32'h0;
         rd_ex       <= 5'd0;
         rs1_ex      <= 5'd0;
         rs2_ex      <= 5'd0;
         alu_op_ex   <= 4'd0;
         funct3_ex   <= 3'd0;
         ctrl_ex     <= 7'd0;
      end else begin
         valid_ex    <= accept;
         illegal_o   <= illegal_next;
         pc_ex       <= pc_i;
         rs1_data_ex <= rs1_val;
         rs2_data_ex <= rs2_val;
         imm_ex      <= imm;
         rs1_ex      <= rs1_idx;
         rs2_ex      <= rs2_idx;
         alu_op_ex   <= alu_op;
         funct3_ex   <= f3;
         // A bubble only has to be harmless: no write, no memory, no branch.
         rd_ex       <= accept ? rd_dec : 5'd0;
         ctrl_ex     <= accept ? {reg_we, alu_src_imm, is_load, is_store,
                                  is_branch, is_jal, is_jalr} : 7'd0;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//   Directed vectors with hand-computed ID/EX and hazard expectations.
//   Inputs are driven on the falling edge; hazard_o is checked shortly after
//   (same cycle), the ID/EX image is checked just after the next rising edge.
// ---------------------------------------------------------------------------
module tb_decode_stage;

   localparam int W = 159;
   // {valid, illegal, ctrl, rd} -- the only fields that matter in a bubble
   localparam logic [W-1:0] M_ALL = {W{1'b1}};
   localparam logic [W-1:0] M_BUB = {14'h3fff, 145'h0};

   logic        clk, reset;
   logic [31:0] pc_i, instr_i, wb_data_i;
   logic        flush_i, wb_we_i;
   logic [4:0]  wb_rd_i;
   logic        hazard_o, valid_ex, illegal_o;
   logic [31:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
   logic [4:0]  rd_ex, rs1_ex, rs2_ex;
   logic [3:0]  alu_op_ex;
   logic [2:0]  funct3_ex;
   logic [6:0]  ctrl_ex;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] mask_q[$];
   string        name_q[$];
   logic         hz_q[$];
   string        hz_name_q[$];
   int           n_vec = 0;
   int           n_err = 0;

   decode_stage #(.WB_BYPASS(1'b1)) dut (
      .clk(clk), .reset(reset), .pc_i(pc_i), .instr_i(instr_i),
      .flush_i(flush_i), .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i),
      .wb_data_i(wb_data_i), .hazard_o(hazard_o), .valid_ex(valid_ex),
      .pc_ex(pc_ex), .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex),
      .imm_ex(imm_ex), .rd_ex(rd_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
      .alu_op_ex(alu_op_ex), .funct3_ex(funct3_ex), .ctrl_ex(ctrl_ex),
      .illegal_o(illegal_o)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [W-1:0] mk(input logic v, input logic ill,
                                       input logic [6:0] ctrl, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [3:0] alu, input logic [2:0] f3,
                                       input logic [31:0] pc, input logic [31:0] d1,
                                       input logic [31:0] d2, input logic [31:0] imm);
      return {v, ill, ctrl, rd, rs1, rs2, alu, f3, pc, d1, d2, imm};
   endfunction

   function automatic logic [W-1:0] bub(input logic ill);
      return mk(1'b0, ill, 7'd0, 5'd0, 5'd0, 5'd0, 4'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
   endfunction

   // LW x7,0(x1)
   function automatic logic [W-1:0] lw_exp(input logic [31:0] pc);
      return mk(1'b1, 1'b0, 7'b1110000, 5'd7, 5'd1, 5'd0, 4'd0, 3'd2, pc, 32'h0, 32'h0, 32'h0);
   endfunction

   // driver
   task automatic vec(input string name, input logic rst, input logic fl,
                      input logic [31:0] ins, input logic [31:0] pc,
                      input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                      input logic [W-1:0] e, input logic [W-1:0] m, input logic hz);
      @(negedge clk);
      reset     = rst;
      flush_i   = fl;
      instr_i   = ins;
      pc_i      = pc;
      wb_we_i   = we;
      wb_rd_i   = wrd;
      wb_data_i = wd;
      exp_q.push_back(e);
      mask_q.push_back(m);
      name_q.push_back(name);
      hz_q.push_back(hz);
      hz_name_q.push_back(name);
   endtask

   // scoreboard: ID/EX image, one cycle after the vector
   initial begin
      logic [W-1:0] act, e, m;
      string        nm;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            m  = mask_q.pop_front();
            nm = name_q.pop_front();
            act = {valid_ex, illegal_o, ctrl_ex, rd_ex, rs1_ex, rs2_ex, alu_op_ex,
                   funct3_ex, pc_ex, rs1_data_ex, rs2_data_ex, imm_ex};
            n_vec++;
            if (((act ^ e) & m) !== {W{1'b0}}) begin
               n_err++;
               $display("FAIL idex %s: got %h want %h mask %h", nm, act, e, m);
            end
         end
      end
   end

   // scoreboard: combinational hazard_o, same cycle as the vector
   initial begin
      logic  e;
      string nm;
      forever begin
         @(negedge clk);
         #2;
         if (hz_q.size() > 0) begin
            e  = hz_q.pop_front();
            nm = hz_name_q.pop_front();
            n_vec++;
            if (hazard_o !== e) begin
               n_err++;
               $display("FAIL hazard %s: got %b want %b", nm, hazard_o, e);
            end
         end
      end
   end

   localparam logic [31:0] I_ADD_656  = 32'h00528333; // add  x6,x5,x5
   localparam logic [31:0] I_ADDI_435 = 32'h00518213; // addi x4,x3,5
   localparam logic [31:0] I_ADD_D03  = 32'h003006B3; // add  x13,x0,x3
   localparam logic [31:0] I_ADD_E00  = 32'h00000733; // add  x14,x0,x0
   localparam logic [31:0] I_BEQ      = 32'hFE208CE3; // beq  x1,x2,-8
   localparam logic [31:0] I_LW       = 32'h0000A383; // lw   x7,0(x1)
   localparam logic [31:0] I_ADDI_871 = 32'h00138413; // addi x8,x7,1
   localparam logic [31:0] I_SW_56    = 32'h00532623; // sw   x5,12(x6)
   localparam logic [31:0] I_LUI      = 32'hABCDE4B7; // lui  x9,0xabcde
   localparam logic [31:0] I_SRAI     = 32'h4042D513; // srai x10,x5,4
   localparam logic [31:0] I_SUB      = 32'h406285B3; // sub  x11,x5,x6
   localparam logic [31:0] I_AUIPC    = 32'h00001617; // auipc x12,1
   localparam logic [31:0] I_SW_72    = 32'h00712023; // sw   x7,0(x2)
   localparam logic [31:0] I_ADD_D09  = 32'h009006B3; // add  x13,x0,x9

   initial begin
      reset = 1'b1; flush_i = 1'b0; instr_i = 32'h0; pc_i = 32'h0;
      wb_we_i = 1'b0; wb_rd_i = 5'd0; wb_data_i = 32'h0;
      repeat (2) @(posedge clk);

      vec("reset", 1, 1, I_ADD_656, 32'h4, 1, 5'd5, 32'hAAAA, bub(0), M_ALL, 0);
      vec("wr_x5", 0, 0, 32'h0, 32'h0, 1, 5'd5, 32'h12345678, bub(0), M_BUB, 0);
      vec("add_x5x5", 0, 0, I_ADD_656, 32'h10, 0, 5'd0, 32'h0,
          mk(1, 0, 7'b1000000, 6, 5, 5, 0, 0, 32'h10, 32'h12345678, 32'h12345678, 0), M_ALL, 0);
      vec("bypass_x3", 0, 0, I_ADDI_435, 32'h14, 1, 5'd3, 32'hDEADBEEF,
          mk(1, 0, 7'b1100000, 4, 3, 0, 0, 0, 32'h14, 32'hDEADBEEF, 0, 5), M_ALL, 0);
      vec("wr_x0_rd_x3", 0, 0, I_ADD_D03, 32'h18, 1, 5'd0, 32'h1,
          mk(1, 0, 7'b1000000, 13, 0, 3, 0, 0, 32'h18, 0, 32'hDEADBEEF, 0), M_ALL, 0);
      vec("rd_x0", 0, 0, I_ADD_E00, 32'h1C, 0, 5'd0, 32'h0,
          mk(1, 0, 7'b1000000, 14, 0, 0, 0, 0, 32'h1C, 0, 0, 0), M_ALL, 0);
      vec("beq_m8", 0, 0, I_BEQ, 32'h100, 0, 5'd0, 32'h0,
          mk(1, 0, 7'b0000100, 0, 1, 2, 1, 0, 32'h100, 0, 0, 32'hFFFFFFF8), M_ALL, 0);
      vec("lw_a", 0, 0, I_LW, 32'h104, 0, 5'd0, 32'h0, lw_exp(32'h104), M_ALL, 0);
      vec("ldu_stall", 0, 0, I_ADDI_871, 32'h108, 0, 5'd0, 32'h0, bub(0), M_BUB, 1);
      vec("ldu_issue", 0, 0, I_ADDI_871, 32'h108, 1, 5'd7, 32'h55,
          mk(1, 0, 7'b1100000, 8, 7, 0, 0, 0, 32'h108, 32'h55, 0, 1), M_ALL, 0);
      vec("lw_b", 0, 0, I_LW, 32'h10C, 0, 5'd0, 32'h0, lw_exp(32'h10C), M_ALL, 0);
      vec("flush_ldu", 0, 1, I_ADDI_871, 32'h110, 0, 5'd0, 32'h0, bub(0), M_BUB, 0);
      vec("illegal", 0, 0, 32'hFFFFFFFF, 32'h114, 0, 5'd0, 32'h0, bub(1), M_BUB, 0);
      vec("illegal_end", 0, 0, 32'h0, 32'h118, 0, 5'd0, 32'h0, bub(0), M_BUB, 0);
      vec("illegal_flush", 0, 1, 32'hFFFFFFFF, 32'h11C, 0, 5'd0, 32'h0, bub(0), M_BUB, 0);
      vec("lw_c", 0, 0, I_LW, 32'h200, 0, 5'd0, 32'h0, lw_exp(32'h200), M_ALL, 0);
      vec("sw_nodep", 0, 0, I_SW_56, 32'h204, 0, 5'd0, 32'h0,
          mk(1, 0, 7'b0101000, 0, 6, 5, 0, 2, 32'h204, 0, 32'h12345678, 12), M_ALL, 0);
      vec("lui", 0, 0, I_LUI, 32'h208, 0, 5'd0, 32'h0,
          mk(1, 0, 7'b1100000, 9, 0, 0, 10, 6, 32'h208, 0, 0, 32'hABCDE000), M_ALL, 0);
      vec("srai", 0, 0, I_SRAI, 32'h20C, 0, 5'd0, 32'h0,
          mk(1, 0, 7'b1100000, 10, 5, 0, 7, 5, 32'h20C, 32'h12345678, 0, 32'h404), M_ALL, 0);
      vec("sub", 0, 0, I_SUB, 32'h210, 0, 5'd0, 32'h0,
          mk(1, 0, 7'b1000000, 11, 5, 6, 1, 0, 32'h210, 32'h12345678, 0, 0), M_ALL, 0);
      vec("auipc", 0, 0, I_AUIPC, 32'h214, 0, 5'd0, 32'h0,
          mk(1, 0, 7'b1100000, 12, 0, 0, 0, 1, 32'h214, 0, 0, 32'h1000), M_ALL, 0);
      vec("lw_d", 0, 0, I_LW, 32'h218, 0, 5'd0, 32'h0, lw_exp(32'h218), M_ALL, 0);
      vec("rs2_stall", 0, 0, I_SW_72, 32'h21C, 0, 5'd0, 32'h0, bub(0), M_BUB, 1);
      vec("rs2_issue", 0, 0, I_SW_72, 32'h21C, 0, 5'd0, 32'h0,
          mk(1, 0, 7'b0101000, 0, 2, 7, 0, 2, 32'h21C, 0, 32'h55, 0), M_ALL, 0);
      vec("lw_e", 0, 0, I_LW, 32'h220, 0, 5'd0, 32'h0, lw_exp(32'h220), M_ALL, 0);
      vec("reset_stall", 1, 0, I_SW_72, 32'h224, 1, 5'd9, 32'h77, bub(0), M_ALL, 0);
      vec("post_reset", 0, 0, I_SW_72, 32'h224, 0, 5'd0, 32'h0,
          mk(1, 0, 7'b0101000, 0, 2, 7, 0, 2, 32'h224, 0, 0, 0), M_ALL, 0);
      vec("rd_x9_clr", 0, 0, I_ADD_D09, 32'h228, 0, 5'd0, 32'h0,
          mk(1, 0, 7'b1000000, 13, 0, 9, 0, 0, 32'h228, 0, 0, 0), M_ALL, 0);
      vec("rd_x5_clr", 0, 0, I_SUB, 32'h22C, 0, 5'd0, 32'h0,
          mk(1, 0, 7'b1000000, 11, 5, 6, 1, 0, 32'h22C, 0, 0, 0), M_ALL, 0);

      @(negedge clk);
      instr_i = 32'h0; wb_we_i = 1'b0; flush_i = 1'b0;
      for (int i = 0; i < 10 && (exp_q.size() > 0 || hz_q.size() > 0); i++)
         @(posedge clk);
      @(negedge clk);
      if (exp_q.size() > 0 || hz_q.size() > 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size() + hz_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
